alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 98 +++++++++
 tb/tb_alu_exec_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 32-bit combinational ALU with an execute pipeline register
// and a free-running modulo-NUM_STAGES stage counter.
// Optional build macro ALU_EXEC_DEBUG_EN exposes the ALU select and operands
// as dbg_op_select / dbg_in0 / dbg_in1.
module alu_exec_unit #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         alu_operation,
    input  logic [31:0]        reg_value_0,
    input  logic [31:0]        reg_value_1,
    output logic [31:0]        alu_comb,
    output logic [31:0]        alu_result,
    output logic [STAGE_W-1:0] stage
`ifdef ALU_EXEC_DEBUG_EN
    ,
    output logic [4:0]         dbg_op_select,
    output logic [31:0]        dbg_in0,
    output logic [31:0]        dbg_in1
`endif
);

    // Opcodes as emitted by the instruction decoder
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_EQ   = 5'd8;
    localparam logic [4:0] OP_SLT  = 5'd9;
    localparam logic [4:0] OP_SLTU = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_PASS = 5'd12;

    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

    // Catch illegal counter configurations at elaboration time
    if (NUM_STAGES < 2 || NUM_STAGES > 16 || (1 << STAGE_W) < NUM_STAGES) begin : g_bad_cfg
        $error("alu_exec_unit: illegal NUM_STAGES/STAGE_W combination");
    end

    // Control: operands and select go straight through, untouched
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [4:0]  op_select;
    logic [4:0]  shamt;

    assign alu_in0   = reg_value_0;
    assign alu_in1   = reg_value_1;
    assign op_select = alu_operation;
    assign shamt     = alu_in1[4:0];   // upper shift bits are ignored

`ifdef ALU_EXEC_DEBUG_EN
    assign dbg_op_select = op_select;
    assign dbg_in0       = alu_in0;
    assign dbg_in1       = alu_in1;
`endif

    // ALU datapath; carries/overflow dropped, compares zero-extended, unused codes give 0
    always_comb begin
        alu_comb = 32'h0;
        case (op_select)
            OP_ADD:  alu_comb = alu_in0 + alu_in1;
            OP_SUB:  alu_comb = alu_in0 - alu_in1;
            OP_AND:  alu_comb = alu_in0 & alu_in1;
            OP_OR:   alu_comb = alu_in0 | alu_in1;
            OP_XOR:  alu_comb = alu_in0 ^ alu_in1;
            OP_SLL:  alu_comb = alu_in0 << shamt;
            OP_SRL:  alu_comb = alu_in0 >> shamt;
            OP_SRA:  alu_comb = $unsigned($signed(alu_in0) >>> shamt);
            OP_EQ:   alu_comb = {31'h0, alu_in0 == alu_in1};
            OP_SLT:  alu_comb = {31'h0, $signed(alu_in0) < $signed(alu_in1)};
            OP_SLTU: alu_comb = {31'h0, alu_in0 < alu_in1};
            OP_NOT:  alu_comb = ~alu_in0;
            OP_PASS: alu_comb = alu_in1;
            default: alu_comb = 32'h0;
        endcase
    end

    // Execute pipeline register, loads every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_result <= 32'h0;
        else      alu_result <= alu_comb;
    end

    // Stage counter, wraps at NUM_STAGES-1 so out-of-range values never appear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     stage <= '0;
        else if (stage == STAGE_LAST) stage <= '0;
        else                          stage <= stage + STAGE_W'(1);
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed corner cases plus random ops against an
// arithmetic reference model of the ALU and the stage counter.
module tb_alu_exec_unit;

    localparam int NUM_STAGES = 5;
    localparam int STAGE_W    = 3;
    localparam longint M      = 64'sh1_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [4:0]         alu_operation;
    logic [31:0]        reg_value_0;
    logic [31:0]        reg_value_1;
    logic [31:0]        alu_comb;
    logic [31:0]        alu_result;
    logic [STAGE_W-1:0] stage;

    int n_chk = 0;
    int n_err = 0;
    int exp_stage;
    logic [31:0] exp_res;

    alu_exec_unit #(.NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W)) dut (
        .clk(clk), .rst(rst), .alu_operation(alu_operation),
        .reg_value_0(reg_value_0), .reg_value_1(reg_value_1),
        .alu_comb(alu_comb), .alu_result(alu_result), .stage(stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU computed with plain integer arithmetic on 64-bit values
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, d, q, r;
        int sh;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(ub % 32);
        d  = longint'(1) << sh;
        case (int'(op))
            0:  r = (ua + ub) % M;
            1:  r = (ua - ub + M) % M;
            2:  r = longint'(a & b);
            3:  r = longint'(a | b);
            4:  r = longint'(a ^ b);
            5:  r = (ua % (M / d)) * d;
            6:  r = ua / d;
            7: begin
                q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;  // floor division
                r = ((q % M) + M) % M;
            end
            8:  r = (ua == ub) ? 1 : 0;
            9:  r = (sa < sb) ? 1 : 0;
            10: r = (ua < ub) ? 1 : 0;
            11: r = M - 1 - ua;
            12: r = ub;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_operation = op;
        reg_value_0   = a;
        reg_value_1   = b;
        #1;
    endtask

    // One clock edge: update the model, then sample just after the edge
    task automatic tick();
        logic [31:0] nxt;
        nxt = ref_alu(alu_operation, reg_value_0, reg_value_1);
        @(posedge clk);
        if (rst) begin
            exp_res   = nxt;
            exp_stage = (exp_stage + 1) % NUM_STAGES;
        end
        #1;
        chk("stage", 32'(stage), 32'(exp_stage));
        chk("alu_result", alu_result, exp_res);
    endtask

    task automatic op_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] want);
        drive(op, a, b);
        chk(tag, alu_comb, want);
        chk({tag, "_model"}, ref_alu(op, a, b), want);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        exp_stage = 0;
        exp_res   = 32'h0;
        drive(5'd0, 32'h1234_5678, 32'h1111_1111);
        // Reset held across three edges
        repeat (3) tick();
        chk("rst_stage", 32'(stage), 32'h0);
        chk("rst_result", alu_result, 32'h0);
        chk("rst_comb_live", alu_comb, 32'h2345_6789);

        // Release away from an edge, then watch the 1,2,3,4,0,1 sequence
        rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) tick();

        // Directed corner cases
        op_check("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'h1, 32'h0);
        chk("add_wrap_reg", alu_result, 32'h0);
        op_check("sub_neg",  5'd1,  32'd5, 32'd7, 32'hFFFF_FFFE);
        op_check("sll_big",  5'd5,  32'h8000_0000, 32'h21, 32'h0);
        op_check("srl_big",  5'd6,  32'h8000_0000, 32'h21, 32'h4000_0000);
        op_check("sra_big",  5'd7,  32'h8000_0000, 32'h21, 32'hC000_0000);
        op_check("slt_neg",  5'd9,  32'hFFFF_FFFF, 32'h1, 32'h1);
        op_check("sltu_neg", 5'd10, 32'hFFFF_FFFF, 32'h1, 32'h0);
        op_check("eq_ne",    5'd8,  32'hFFFF_FFFF, 32'h1, 32'h0);
        op_check("eq_eq",    5'd8,  32'd7, 32'd7, 32'h1);
        op_check("illegal",  5'd20, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0);
        op_check("not",      5'd11, 32'h0F0F_00FF, 32'h0, 32'hF0F0_FF00);
        op_check("pass1",    5'd12, 32'h1, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        // Random operations over all 32 codes
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = $urandom();
            if (i % 4 == 0) b = b & 32'h3F;           // realistic shift amounts
            if (i % 7 == 0) b = a;                    // exercise EQ/SLT equality
            drive(5'($urandom_range(0, 31)), a, b);
            chk("rand_comb", alu_comb, ref_alu(alu_operation, reg_value_0, reg_value_1));
            tick();
        end

        // Mid-count reset: advance to stage 3, then reset between edges
        for (int i = 0; i < 2 * NUM_STAGES && exp_stage != 3; i++) tick();
        chk("at_stage3", 32'(stage), 32'h3);
        drive(5'd3, 32'hF000_0000, 32'h0000_000F);
        tick();
        #2;
        rst = 1'b0;
        exp_stage = 0;
        exp_res   = 32'h0;
        #1;
        chk("midrst_stage", 32'(stage), 32'h0);
        chk("midrst_result", alu_result, 32'h0);
        chk("midrst_comb_live", alu_comb, 32'hF000_000F);
        #1;
        rst = 1'b1;
        #1;
        tick();
        chk("restart_stage", 32'(stage), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    // Hard timeout so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
